pipe_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage MIPS datapath (IF, IF_ID, ID_EX, EX_MEM, MEM_WB).
- Decides every cycle whether each pipeline element advances, holds or is flushed:
  - load-use stall detection;
  - branch and jump redirect flushing;
  - ALU operand forwarding selects.
- Owns a debug run-control FSM (RUN / HALTING / HALTED / STEP) that drains the pipeline on halt and supports single-step.
- Keeps saturating performance counters.
- Outputs drive the new enable/flush inputs added to PC, IF_ID, ID_EX, EX_MEM and MEM_WB, plus select lines on the EX-stage operand muxes.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/fwd_unit.sv | 32 +++
 rtl/pipe_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller and its forwarding units.
package pipe_ctrl_pkg;

    localparam int DEF_REG_AW = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTING = 2'd1,
        HALTED  = 2'd2,
        STEP    = 2'd3
    } runState_t;

    // EX-stage operand mux selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX-stage ALU source.
// The younger result in EX_MEM wins over MEM_WB; register 0 is never forwarded.
module fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int AW = DEF_REG_AW
) (
    input  logic [AW-1:0] src,
    input  logic          memRegwrite,
    input  logic [AW-1:0] memRd,
    input  logic          wbRegwrite,
    input  logic [AW-1:0] wbRd,
    output logic [1:0]    sel
);

    logic memHit;
    logic wbHit;

    assign memHit = memRegwrite && (memRd != '0) && (memRd == src);
    assign wbHit  = wbRegwrite  && (wbRd  != '0) && (wbRd  == src);

    // Pick the most recent producer of src
    always_comb begin
        sel = FWD_RF;
        if (memHit) begin
            sel = FWD_MEM;
        end else if (wbHit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central controller for the 5-stage pipeline: stage enables/flushes,
// operand forwarding selects, debug run control and performance counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal execution, fetch every cycle
// HALTING | fetch stopped, bubbles injected into ID while the pipe drains
// HALTED  | pipeline empty, PC frozen, waiting for resume or step
// STEP    | one fetch cycle, then drain again
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32,
    parameter int REG_AW       = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_req,
    input  logic              resume_req,
    input  logic              step_req,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              redirect_mem,
    input  logic              redirect_wb,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Drain counter counts down from DRAIN_CYCLES-1; terminal count is zero.
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    runState_t        state;
    runState_t        nextState;
    logic [DW-1:0]    drainCnt;
    logic [DW-1:0]    drainNext;
    logic             haltedQ;
    logic [CNT_W-1:0] stallCntQ;
    logic [CNT_W-1:0] flushCntQ;

    logic             loadUse;
    logic             redirect;
    logic             stall;
    logic             drainDone;
    logic [1:0]       fwdASel;
    logic [1:0]       fwdBSel;

    assign loadUse   = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign redirect  = redirect_mem || redirect_wb;
    // A redirect squashes the instruction that would have stalled
    assign stall     = loadUse && !redirect;
    assign drainDone = (drainCnt == '0);

    fwd_unit #(.AW(REG_AW)) uFwdA (
        .src         (ex_rs),
        .memRegwrite (mem_regwrite),
        .memRd       (mem_rd),
        .wbRegwrite  (wb_regwrite),
        .wbRd        (wb_rd),
        .sel         (fwdASel)
    );

    fwd_unit #(.AW(REG_AW)) uFwdB (
        .src         (ex_rt),
        .memRegwrite (mem_regwrite),
        .memRd       (mem_rd),
        .wbRegwrite  (wb_regwrite),
        .wbRd        (wb_rd),
        .sel         (fwdBSel)
    );

    assign fwd_a     = rst ? FWD_RF : fwdASel;
    assign fwd_b     = rst ? FWD_RF : fwdBSel;
    assign halted    = haltedQ;
    assign stall_cnt = stallCntQ;
    assign flush_cnt = flushCntQ;

    // Stage enables/flushes: run-control baseline, then stall, redirect, reset override it
    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;

        case (state)
            RUN, STEP: begin
                pc_we    = 1'b1;
                if_id_we = 1'b1;
            end
            HALTING, HALTED: begin
                // IF_ID keeps loading, but only bubbles
                if_id_we    = 1'b1;
                if_id_flush = 1'b1;
            end
            default: ;
        endcase

        if (rst) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (redirect) begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = redirect_wb;
        end else if (stall) begin
            // IF_ID must hold the dependent instruction, even while draining
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    // Run-control next state and drain countdown
    always_comb begin
        nextState = state;
        drainNext = drainCnt;

        case (state)
            RUN: begin
                if (halt_req) begin
                    nextState = HALTING;
                    drainNext = DRAIN_LOAD;
                end
            end
            HALTING: begin
                if (redirect) begin
                    // New instructions entered behind the redirect; drain from scratch
                    drainNext = DRAIN_LOAD;
                end else if (!stall) begin
                    if (drainDone) begin
                        nextState = HALTED;
                    end else begin
                        drainNext = drainCnt - DW'(1);
                    end
                end
            end
            HALTED: begin
                if (resume_req) begin
                    nextState = RUN;
                end else if (step_req) begin
                    nextState = STEP;
                end
            end
            STEP: begin
                nextState = HALTING;
                drainNext = DRAIN_LOAD;
            end
            default: begin
                nextState = RUN;
            end
        endcase
    end

    // Run-control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            drainCnt <= '0;
            haltedQ  <= 1'b0;
        end else begin
            state    <= nextState;
            drainCnt <= drainNext;
            haltedQ  <= (nextState == HALTED);
        end
    end

    // Saturating performance counters, active in every run-control state
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (stall && (stallCntQ != '1)) begin
                stallCntQ <= stallCntQ + CNT_W'(1);
            end
            if (redirect && (flushCntQ != '1)) begin
                flushCntQ <= flushCntQ + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes expected per-cycle outputs
// from a behavioural model, a negedge monitor pops and compares.
module tb_pipe_ctrl;

    localparam int DRAIN = 4;
    localparam int M_RUN = 0, M_HALTING = 1, M_HALTED = 2, M_STEP = 3;

    logic       clk = 1'b0;
    logic       rst, haltReq, resumeReq, stepReq;
    logic [4:0] idRs, idRt, exRs, exRt, memRd, wbRd;
    logic       exMemread, memRegwrite, wbRegwrite, redMem, redWb;

    logic        pcWe, ifIdWe, ifIdFlush, idExFlush, exMemFlush, memWbFlush, halted;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] stallCnt, flushCnt;

    logic        sPcWe, sIfIdWe, sIfIdFlush, sIdExFlush, sExMemFlush, sMemWbFlush, sHalted;
    logic [1:0]  sFwdA, sFwdB;
    logic [3:0]  sStallCnt, sFlushCnt;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        pcWe, ifIdWe, ifIdWeCare, ifIdFlush, idExFlush, exMemFlush, memWbFlush, halted;
        logic [1:0]  fwdA, fwdB;
        logic [31:0] stallCnt, flushCnt;
        logic [3:0]  stallSat, flushSat;
    } exp_t;

    exp_t expQ[$];

    // behavioural model state
    int     mode = M_RUN;
    int     cleanLeft = 0;
    longint stallM = 0, flushM = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .halt_req(haltReq), .resume_req(resumeReq), .step_req(stepReq),
        .id_rs(idRs), .id_rt(idRt), .ex_memread(exMemread), .ex_rs(exRs), .ex_rt(exRt),
        .mem_regwrite(memRegwrite), .mem_rd(memRd), .wb_regwrite(wbRegwrite), .wb_rd(wbRd),
        .redirect_mem(redMem), .redirect_wb(redWb),
        .pc_we(pcWe), .if_id_we(ifIdWe), .if_id_flush(ifIdFlush), .id_ex_flush(idExFlush),
        .ex_mem_flush(exMemFlush), .mem_wb_flush(memWbFlush), .fwd_a(fwdA), .fwd_b(fwdB),
        .halted(halted), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
    );

    pipe_ctrl #(.CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .halt_req(haltReq), .resume_req(resumeReq), .step_req(stepReq),
        .id_rs(idRs), .id_rt(idRt), .ex_memread(exMemread), .ex_rs(exRs), .ex_rt(exRt),
        .mem_regwrite(memRegwrite), .mem_rd(memRd), .wb_regwrite(wbRegwrite), .wb_rd(wbRd),
        .redirect_mem(redMem), .redirect_wb(redWb),
        .pc_we(sPcWe), .if_id_we(sIfIdWe), .if_id_flush(sIfIdFlush), .id_ex_flush(sIdExFlush),
        .ex_mem_flush(sExMemFlush), .mem_wb_flush(sMemWbFlush), .fwd_a(sFwdA), .fwd_b(sFwdB),
        .halted(sHalted), .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] satTo(input longint v, input longint maxV);
        return (v > maxV) ? 32'(maxV) : 32'(v);
    endfunction

    function automatic logic [1:0] refFwd(input logic [4:0] src);
        if (memRegwrite && memRd != 5'd0 && memRd == src) return 2'b10;
        if (wbRegwrite && wbRd != 5'd0 && wbRd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic setIdle();
        rst = 1'b0; haltReq = 1'b0; resumeReq = 1'b0; stepReq = 1'b0;
        idRs = 5'd0; idRt = 5'd0; exRs = 5'd0; exRt = 5'd0; memRd = 5'd0; wbRd = 5'd0;
        exMemread = 1'b0; memRegwrite = 1'b0; wbRegwrite = 1'b0; redMem = 1'b0; redWb = 1'b0;
    endtask

    // Predict this cycle's outputs, queue them, advance the model, wait one clock.
    task automatic driveCycle();
        exp_t e;
        bit   red, lu, st;
        red = redMem || redWb;
        lu  = exMemread && exRt != 5'd0 && (exRt == idRs || exRt == idRt);
        st  = lu && !red;

        e.halted   = (mode == M_HALTED);
        e.stallCnt = satTo(stallM, 64'hFFFF_FFFF);
        e.flushCnt = satTo(flushM, 64'hFFFF_FFFF);
        e.stallSat = 4'(satTo(stallM, 15));
        e.flushSat = 4'(satTo(flushM, 15));
        e.fwdA     = rst ? 2'b00 : refFwd(exRs);
        e.fwdB     = rst ? 2'b00 : refFwd(exRt);
        e.ifIdWeCare = 1'b1;
        e.pcWe = 0; e.ifIdWe = 0; e.ifIdFlush = 0; e.idExFlush = 0; e.exMemFlush = 0; e.memWbFlush = 0;

        if (rst) begin
            e.ifIdFlush = 1; e.idExFlush = 1; e.exMemFlush = 1; e.memWbFlush = 1;
        end else if (red) begin
            e.pcWe = 1; e.ifIdWe = 1; e.ifIdFlush = 1; e.idExFlush = 1; e.exMemFlush = 1;
            e.memWbFlush = redWb;
        end else if (st) begin
            e.idExFlush = 1;
        end else if (mode == M_RUN || mode == M_STEP) begin
            e.pcWe = 1; e.ifIdWe = 1;
        end else if (mode == M_HALTING) begin
            e.ifIdWe = 1; e.ifIdFlush = 1;
        end else begin
            e.ifIdWeCare = 0; e.ifIdFlush = 1;
        end
        expQ.push_back(e);

        if (rst) begin
            mode = M_RUN; cleanLeft = 0; stallM = 0; flushM = 0;
        end else begin
            if (st) stallM++;
            if (red) flushM++;
            case (mode)
                M_RUN: if (haltReq) begin mode = M_HALTING; cleanLeft = DRAIN; end
                M_STEP: begin mode = M_HALTING; cleanLeft = DRAIN; end
                M_HALTING: begin
                    // need DRAIN hazard-free cycles after the last fetch
                    if (red) cleanLeft = DRAIN;
                    else if (!lu) begin
                        cleanLeft--;
                        if (cleanLeft == 0) mode = M_HALTED;
                    end
                end
                default: begin
                    if (resumeReq) mode = M_RUN;
                    else if (stepReq) mode = M_STEP;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // Drive idle cycles until halted rises; returns the number of cycles driven
    task automatic waitHalted(output int n);
        n = 0;
        while (halted !== 1'b1 && n < 30) begin
            driveCycle();
            n++;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("pc_we", 32'(pcWe), 32'(e.pcWe));
            if (e.ifIdWeCare) chk("if_id_we", 32'(ifIdWe), 32'(e.ifIdWe));
            chk("if_id_flush", 32'(ifIdFlush), 32'(e.ifIdFlush));
            chk("id_ex_flush", 32'(idExFlush), 32'(e.idExFlush));
            chk("ex_mem_flush", 32'(exMemFlush), 32'(e.exMemFlush));
            chk("mem_wb_flush", 32'(memWbFlush), 32'(e.memWbFlush));
            chk("fwd_a", 32'(fwdA), 32'(e.fwdA));
            chk("fwd_b", 32'(fwdB), 32'(e.fwdB));
            chk("halted", 32'(halted), 32'(e.halted));
            chk("stall_cnt", stallCnt, e.stallCnt);
            chk("flush_cnt", flushCnt, e.flushCnt);
            chk("stall_cnt_w4", 32'(sStallCnt), 32'(e.stallSat));
            chk("flush_cnt_w4", 32'(sFlushCnt), 32'(e.flushSat));
        end
    end

    initial begin
        int n;
        setIdle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        driveCycle();
        driveCycle();
        rst = 1'b0;
        driveCycle();

        // load-use on rs, on rt, and the rt==0 non-hazard
        exMemread = 1; exRt = 5'd2; idRs = 5'd2; driveCycle();
        setIdle(); driveCycle();
        exMemread = 1; exRt = 5'd7; idRt = 5'd7; idRs = 5'd1; driveCycle();
        setIdle(); exMemread = 1; exRt = 5'd0; driveCycle();

        // forwarding priority and fallbacks
        setIdle();
        memRegwrite = 1; wbRegwrite = 1; memRd = 5'd5; wbRd = 5'd5; exRs = 5'd5; exRt = 5'd5;
        driveCycle();
        memRd = 5'd0; driveCycle();
        wbRegwrite = 0; driveCycle();
        exRs = 5'd3; wbRegwrite = 1; wbRd = 5'd3; memRd = 5'd5; driveCycle();

        // redirect beats load-use
        setIdle(); exMemread = 1; exRt = 5'd4; idRs = 5'd4;
        redMem = 1; driveCycle();
        redMem = 0; redWb = 1; driveCycle();
        redMem = 1; driveCycle();
        setIdle(); driveCycle();

        // halt, latency, ignored halt_req while halted, resume
        haltReq = 1; driveCycle();
        haltReq = 0;
        waitHalted(n);
        chk("halt_latency", 32'(n + 1), 32'd5);
        haltReq = 1; driveCycle(); driveCycle();
        haltReq = 0; resumeReq = 1; stepReq = 1; driveCycle();
        setIdle(); driveCycle();

        // single step
        haltReq = 1; driveCycle();
        haltReq = 0; waitHalted(n);
        stepReq = 1; driveCycle();
        stepReq = 0; driveCycle();
        waitHalted(n);
        chk("step_latency", 32'(n + 1), 32'd5);

        // redirect during HALTING restarts the drain
        resumeReq = 1; driveCycle();
        setIdle();
        haltReq = 1; driveCycle();
        haltReq = 0; driveCycle();
        redMem = 1; driveCycle();
        redMem = 0; waitHalted(n);
        chk("redirect_halt_latency", 32'(n + 3), 32'd7);

        // stall while draining freezes the countdown
        resumeReq = 1; driveCycle();
        setIdle();
        haltReq = 1; driveCycle();
        haltReq = 0; exMemread = 1; exRt = 5'd9; idRs = 5'd9; driveCycle(); driveCycle();
        setIdle(); waitHalted(n);
        chk("stall_halt_latency", 32'(n + 3), 32'd7);

        // reset in the middle of HALTING
        resumeReq = 1; driveCycle();
        setIdle();
        haltReq = 1; driveCycle();
        haltReq = 0; driveCycle();
        rst = 1; driveCycle();
        rst = 0; driveCycle(); driveCycle();

        // saturation of the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            setIdle(); exMemread = 1; exRt = 5'd6; idRt = 5'd6; driveCycle();
        end
        for (int i = 0; i < 20; i++) begin
            setIdle(); redWb = 1; driveCycle();
        end
        chk("stall_sat_w4", 32'(sStallCnt), 32'hF);
        chk("flush_sat_w4", 32'(sFlushCnt), 32'hF);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            haltReq     = ($urandom_range(0, 19) == 0);
            resumeReq   = ($urandom_range(0, 9) == 0);
            stepReq     = ($urandom_range(0, 9) == 0);
            idRs        = 5'($urandom_range(0, 3));
            idRt        = 5'($urandom_range(0, 3));
            exRs        = 5'($urandom_range(0, 3));
            exRt        = 5'($urandom_range(0, 3));
            memRd       = 5'($urandom_range(0, 3));
            wbRd        = 5'($urandom_range(0, 3));
            exMemread   = ($urandom_range(0, 3) == 0);
            memRegwrite = 1'($urandom_range(0, 1));
            wbRegwrite  = 1'($urandom_range(0, 1));
            redMem      = ($urandom_range(0, 19) == 0);
            redWb       = ($urandom_range(0, 19) == 0);
            driveCycle();
        end

        setIdle();
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        chk("queue_drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
